// File: rtl/hline_pkg.sv
// Shared types and AXI encodings for the hline z-buffer AXI bridge.
package hline_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_t;

  localparam logic [2:0] AXI_SIZE_32    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

  // Map a requested beat count onto 1..max_len (0 means a single beat).
  function automatic logic [4:0] clamp_len(input logic [4:0] len, input logic [4:0] max_len);
    if (len == 5'd0)
      return 5'd1;
    else if (len > max_len)
      return max_len;
    else
      return len;
  endfunction

endpackage

// File: rtl/hline_axi_bridge.sv
// AXI4 master that services the hline z-buffer FSM's read/write burst requests.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for rd_req (priority) or wr_req
// AR      | read address presented, waiting for ARREADY
// R       | accepting read beats into the zread FIFO
// AW      | write address presented, waiting for AWREADY
// W       | streaming zbuffout/byte-enable FIFO words as write beats
// B       | waiting for the write response
// DONE    | one-cycle axi_done pulse
module hline_axi_bridge
  import hline_pkg::*;
#(
  parameter int                MAX_BURST = 16,
  parameter int                ID_W      = 4,
  parameter logic [ID_W-1:0]   AXI_ID    = '0
) (
  input  logic            clk,
  input  logic            reset,
  // request side
  input  logic            rd_req,
  input  logic            wr_req,
  input  logic [31:0]     addr,
  input  logic [4:0]      burst_len,
  output logic            axi_done,
  output logic            bus_err,
  // zread FIFO
  output logic [31:0]     zfifo_in,
  output logic            write_zfifo,
  input  logic            zfifo_full,
  // zbuffout and byte-enable FIFOs
  input  logic [31:0]     zbuffout_data,
  input  logic            zbuffout_empty,
  output logic            read_zbuffout_fifo,
  input  logic [1:0]      be_data,
  input  logic            be_empty,
  output logic            read_be_fifo,
  // AXI read address
  output logic [ID_W-1:0] m_axi_arid,
  output logic [31:0]     m_axi_araddr,
  output logic [7:0]      m_axi_arlen,
  output logic [2:0]      m_axi_arsize,
  output logic [1:0]      m_axi_arburst,
  output logic            m_axi_arvalid,
  input  logic            m_axi_arready,
  // AXI read data
  input  logic [31:0]     m_axi_rdata,
  input  logic [1:0]      m_axi_rresp,
  input  logic            m_axi_rlast,
  input  logic            m_axi_rvalid,
  output logic            m_axi_rready,
  // AXI write address
  output logic [ID_W-1:0] m_axi_awid,
  output logic [31:0]     m_axi_awaddr,
  output logic [7:0]      m_axi_awlen,
  output logic [2:0]      m_axi_awsize,
  output logic [1:0]      m_axi_awburst,
  output logic            m_axi_awvalid,
  input  logic            m_axi_awready,
  // AXI write data
  output logic [31:0]     m_axi_wdata,
  output logic [3:0]      m_axi_wstrb,
  output logic            m_axi_wlast,
  output logic            m_axi_wvalid,
  input  logic            m_axi_wready,
  // AXI write response
  input  logic [1:0]      m_axi_bresp,
  input  logic            m_axi_bvalid,
  output logic            m_axi_bready
);

  localparam logic [4:0] MAX_LEN = 5'(MAX_BURST);

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [4:0]  len_q;
  logic [4:0]  cnt_q;
  logic        err_q;
  logic        last_beat;

  assign last_beat = (cnt_q == (len_q - 5'd1));

  // Constant and pass-through AXI fields.
  assign m_axi_arid    = AXI_ID;
  assign m_axi_awid    = AXI_ID;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_arlen   = {3'b000, len_q - 5'd1};
  assign m_axi_awlen   = {3'b000, len_q - 5'd1};
  assign m_axi_arsize  = AXI_SIZE_32;
  assign m_axi_awsize  = AXI_SIZE_32;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wdata   = zbuffout_data;
  assign m_axi_wstrb   = {{2{be_data[1]}}, {2{be_data[0]}}};
  assign zfifo_in      = m_axi_rdata;
  assign bus_err       = err_q;

  // State register; reset drops every VALID/READY/strobe immediately via IDLE decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt          = state;
    axi_done           = 1'b0;
    write_zfifo        = 1'b0;
    read_zbuffout_fifo = 1'b0;
    read_be_fifo       = 1'b0;
    m_axi_arvalid      = 1'b0;
    m_axi_rready       = 1'b0;
    m_axi_awvalid      = 1'b0;
    m_axi_wvalid       = 1'b0;
    m_axi_wlast        = 1'b0;
    m_axi_bready       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd_req)
          state_nxt = ST_AR;
        else if (wr_req)
          state_nxt = ST_AW;
      end
      ST_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready)
          state_nxt = ST_R;
      end
      ST_R: begin
        m_axi_rready = !zfifo_full;
        write_zfifo  = m_axi_rvalid && !zfifo_full;
        // An early RLAST still terminates the burst; the error is flagged separately.
        if (write_zfifo && (last_beat || m_axi_rlast))
          state_nxt = ST_DONE;
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready)
          state_nxt = ST_W;
      end
      ST_W: begin
        m_axi_wvalid = !zbuffout_empty && !be_empty;
        m_axi_wlast  = last_beat;
        if (m_axi_wvalid && m_axi_wready) begin
          read_zbuffout_fifo = 1'b1;
          read_be_fifo       = 1'b1;
          if (last_beat)
            state_nxt = ST_B;
        end
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid)
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        axi_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, beat counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == ST_IDLE && (rd_req || wr_req)) begin
        addr_q <= addr & 32'hFFFF_FFFC;
        len_q  <= clamp_len(burst_len, MAX_LEN);
        cnt_q  <= '0;
      end else if (write_zfifo || read_zbuffout_fifo) begin
        cnt_q <= cnt_q + 5'd1;
      end
      if (write_zfifo && ((m_axi_rresp != RESP_OKAY) || (m_axi_rlast != last_beat)))
        err_q <= 1'b1;
      if (state == ST_B && m_axi_bvalid && (m_axi_bresp != RESP_OKAY))
        err_q <= 1'b1;
    end
  end

endmodule
